// File: rtl/dft_exp_normalizer_if.sv
// Stream interfaces for dft_exp_normalizer: block-floating-point sink
// (mantissas + frame exponent) and fixed-point source.
interface dft_bfp_if #(parameter int W = 18, parameter int EXP_W = 4);
  logic                valid, ready, sop, eop;
  logic signed [W-1:0] re, im;
  logic [EXP_W-1:0]    exp;
  modport master (output valid, sop, eop, re, im, exp, input ready);
  modport slave  (input valid, sop, eop, re, im, exp, output ready);
endinterface

interface dft_fxp_if #(parameter int W = 24);
  logic                valid, ready, sop, eop;
  logic signed [W-1:0] re, im;
  modport master (output valid, sop, eop, re, im, input ready);
  modport slave  (input valid, sop, eop, re, im, output ready);
endinterface

// File: rtl/dft_exp_normalizer.sv
// Rescales BFP DFT output to saturated fixed point and polices sop/eop framing.
// Optional DFT_NORM_SAT_CNT_EN adds a per-frame saturation counter port sat_cnt.
module dft_exp_normalizer #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 24,
  parameter int EXP_W = 4,
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  dft_bfp_if.slave         snk,
  dft_fxp_if.master        src,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_len_valid,
  output logic             frame_err
`ifdef DFT_NORM_SAT_CNT_EN
  ,
  output logic [15:0]      sat_cnt
`endif
);
  // Shift width holds the largest mantissa shifted by the largest exponent.
  localparam int SH_W = IN_W + (1 << EXP_W) - 1;
  localparam logic [LEN_W-1:0]        LEN_MAX = '1;
  localparam logic [OUT_W-1:0]        POS_OUT = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]        NEG_OUT = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [SH_W-1:0]  POS_MAX = {{(SH_W-OUT_W){1'b0}}, POS_OUT};
  localparam logic signed [SH_W-1:0]  NEG_MIN = {{(SH_W-OUT_W){1'b1}}, NEG_OUT};

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t                  state, state_d;
  logic                    accept, fwd, err_d, len_done_d;
  logic [LEN_W-1:0]        len_cnt, len_d;
  logic [EXP_W-1:0]        exp_q, sh_amt;
  logic signed [SH_W-1:0]  re_ext, im_ext, s1_re, s1_im;
  logic                    s1_vld, s1_sop, s1_eop, s2_load;
  logic [OUT_W:0]          sat_re, sat_im;

  assign s2_load   = s1_vld && (!src.valid || src.ready);
  assign snk.ready = !rst && (!s1_vld || s2_load);
  assign accept    = snk.valid && snk.ready;

  // ---------------- frame FSM ----------------
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_d;

  always_comb begin
    state_d    = state;
    fwd        = 1'b0;
    err_d      = 1'b0;
    len_done_d = 1'b0;
    len_d      = len_cnt;
    if (accept) begin
      if (snk.sop) begin
        // sop always opens a frame; inside a frame it also aborts the old one
        fwd        = 1'b1;
        err_d      = (state == IN_FRAME);
        len_d      = LEN_W'(1);
        len_done_d = snk.eop;
        state_d    = snk.eop ? IDLE : IN_FRAME;
      end else if (state == IN_FRAME) begin
        fwd        = 1'b1;
        len_d      = (len_cnt == LEN_MAX) ? len_cnt : len_cnt + 1'b1;
        len_done_d = snk.eop;
        if (snk.eop) state_d = IDLE;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      len_cnt         <= '0;
      exp_q           <= '0;
      frame_len       <= '0;
      frame_len_valid <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      len_cnt         <= len_d;
      frame_len_valid <= len_done_d;
      frame_err       <= err_d;
      if (len_done_d)         frame_len <= len_d;
      if (accept && snk.sop)  exp_q     <= snk.exp;
    end

  // ---------------- stage 1: shift ----------------
  assign sh_amt = snk.sop ? snk.exp : exp_q;
  assign re_ext = {{(SH_W-IN_W){snk.re[IN_W-1]}}, snk.re};
  assign im_ext = {{(SH_W-IN_W){snk.im[IN_W-1]}}, snk.im};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_vld <= 1'b0;
      s1_sop <= 1'b0;
      s1_eop <= 1'b0;
      s1_re  <= '0;
      s1_im  <= '0;
    end else if (accept) begin
      // dropped beats leave the stage empty, so they carry no markers on
      s1_vld <= fwd;
      s1_sop <= snk.sop;
      s1_eop <= snk.eop;
      s1_re  <= re_ext << sh_amt;
      s1_im  <= im_ext << sh_amt;
    end else if (s2_load) begin
      s1_vld <= 1'b0;
    end

  // ---------------- stage 2: saturate + output register ----------------
  function automatic logic [OUT_W:0] sat(input logic signed [SH_W-1:0] v);
    if (v > POS_MAX)      return {1'b1, POS_OUT};
    else if (v < NEG_MIN) return {1'b1, NEG_OUT};
    else                  return {1'b0, v[OUT_W-1:0]};
  endfunction

  assign sat_re = sat(s1_re);
  assign sat_im = sat(s1_im);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      src.valid <= 1'b0;
      src.sop   <= 1'b0;
      src.eop   <= 1'b0;
      src.re    <= '0;
      src.im    <= '0;
    end else if (s2_load) begin
      src.valid <= 1'b1;
      src.sop   <= s1_sop;
      src.eop   <= s1_eop;
      src.re    <= sat_re[OUT_W-1:0];
      src.im    <= sat_im[OUT_W-1:0];
    end else if (src.ready) begin
      src.valid <= 1'b0;
    end

`ifdef DFT_NORM_SAT_CNT_EN
  logic [1:0]  sat_inc;
  logic [16:0] sat_sum;
  assign sat_inc = {1'b0, sat_re[OUT_W]} + {1'b0, sat_im[OUT_W]};
  // A sop beat reaching stage 2 restarts the count with its own saturations;
  // a sop accepted upstream clears it early so stale beats never leak in.
  assign sat_sum = (s1_sop ? 17'd0 : {1'b0, sat_cnt}) + 17'(sat_inc);

  always_ff @(posedge clk or posedge rst)
    if (rst)                    sat_cnt <= '0;
    else if (accept && snk.sop) sat_cnt <= '0;
    else if (s2_load)           sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
`else
  logic unused_sat;
  assign unused_sat = sat_re[OUT_W] ^ sat_im[OUT_W];
`endif

endmodule

// File: tb/tb_dft_exp_normalizer.sv
// Directed self-checking bench for dft_exp_normalizer.
module tb_dft_exp_normalizer;
  localparam int IN_W = 18, OUT_W = 24, EXP_W = 4, LEN_W = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dft_bfp_if #(.W(IN_W), .EXP_W(EXP_W)) snk ();
  dft_fxp_if #(.W(OUT_W))               src ();
  logic [LEN_W-1:0] frame_len;
  logic             frame_len_valid, frame_err;
`ifdef DFT_NORM_SAT_CNT_EN
  logic [15:0]      sat_cnt;
`endif

  dft_exp_normalizer #(.IN_W(IN_W), .OUT_W(OUT_W), .EXP_W(EXP_W), .LEN_W(LEN_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .snk             (snk),
    .src             (src),
    .frame_len       (frame_len),
    .frame_len_valid (frame_len_valid),
    .frame_err       (frame_err)
`ifdef DFT_NORM_SAT_CNT_EN
    ,
    .sat_cnt         (sat_cnt)
`endif
  );

  typedef struct packed {
    logic             sop;
    logic             eop;
    logic [OUT_W-1:0] re;
    logic [OUT_W-1:0] im;
  } beat_t;

  beat_t            got_q[$], exp_q[$];
  int               got_cyc[$];
  int               n_chk = 0, n_pass = 0;
  int               cyc = 0, err_cnt = 0, len_pulses = 0, sop_acc_cyc = 0;
  int               inflight = 0, full_viol = 0, hold_viol = 0;
  logic [LEN_W-1:0] last_len = '0;
  bit               track = 0, rnd_rdy = 0, hold_rdy = 1;
  bit               prev_stall = 0;
  beat_t            prev, cur;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  // source_ready driver
  always @(negedge clk) src.ready = rnd_rdy ? 1'($urandom_range(0, 1)) : hold_rdy;

  // Monitor samples just before each rising edge.
  always @(negedge clk) begin
    #4;
    cyc++;
    cur = {src.sop, src.eop, src.re, src.im};
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (!src.valid || cur != prev)) hold_viol++;
      if (!track) inflight = 0;
      else begin
        if (src.valid && !src.ready && inflight == 2 && snk.ready) full_viol++;
        if (snk.valid && snk.ready) inflight++;
        if (src.valid && src.ready) inflight--;
      end
      if (snk.valid && snk.ready && snk.sop) sop_acc_cyc = cyc;
      if (src.valid && src.ready) begin
        got_q.push_back(cur);
        got_cyc.push_back(cyc);
      end
      if (frame_err) err_cnt++;
      if (frame_len_valid) begin
        len_pulses++;
        last_len = frame_len;
      end
      prev_stall = src.valid && !src.ready;
      prev       = cur;
    end
  end

  task automatic send(input bit sop, input bit eop, input int re, input int im, input int e);
    int  n = 0;
    bit  ok;
    @(negedge clk);
    snk.valid = 1'b1;
    snk.sop   = sop;
    snk.eop   = eop;
    snk.re    = IN_W'(re);
    snk.im    = IN_W'(im);
    snk.exp   = EXP_W'(e);
    forever begin
      #4 ok = snk.ready;
      @(posedge clk);
      if (ok) break;
      n++;
      if (n >= 300) begin
        chk("send timeout", snk.ready, 1);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    snk.valid = 1'b0;
    snk.sop   = 1'b0;
    snk.eop   = 1'b0;
  endtask

  function automatic logic [OUT_W-1:0] shf(input int v, input int e);
    logic [31:0] t;
    t = v <<< e;
    return t[OUT_W-1:0];
  endfunction

  task automatic push(input bit sop, input bit eop, input logic [OUT_W-1:0] re, input logic [OUT_W-1:0] im);
    exp_q.push_back({sop, eop, re, im});
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (got_q.size() < n && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic cmp(input string tag, input int base);
    int bad = 0;
    chk({tag, " count"}, got_q.size() - base, exp_q.size());
    foreach (exp_q[i])
      if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) bad++;
    chk({tag, " data"}, bad, 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_chk=%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int base, e0, l0, v;
    rst = 1'b1;
    snk.valid = 1'b0; snk.sop = 1'b0; snk.eop = 1'b0;
    snk.re = '0; snk.im = '0; snk.exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst source_valid", src.valid, 0);
    chk("rst source_sop", src.sop, 0);
    chk("rst source_real", src.re, 0);
    chk("rst frame_len", frame_len, 0);
    chk("rst frame_len_valid", frame_len_valid, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst sink_ready", snk.ready, 0);
    @(negedge clk) rst = 1'b0;

    // 1200-beat ramp, exp 0
    base = got_q.size(); e0 = err_cnt; l0 = len_pulses;
    for (int n = 0; n < 1200; n++) begin
      send(n == 0, n == 1199, n, -n, 0);
      push(n == 0, n == 1199, shf(n, 0), shf(-n, 0));
    end
    idle();
    wait_out(base + 1200);
    chk("ramp latency", got_cyc[base] - sop_acc_cyc, 2);
    cmp("ramp", base);
    chk("ramp len pulses", len_pulses - l0, 1);
    chk("ramp frame_len", last_len, 1200);
    chk("ramp no err", err_cnt - e0, 0);

    // saturation at exp 7
    base = got_q.size();
    send(1, 0, 'h1FFFF, 'h20000, 7); push(1, 0, 24'h7FFFFF, 24'h800000);
    send(0, 0, 65535, -65536, 0);    push(0, 0, 24'h7FFF80, 24'h800000);
    send(0, 1, 100, -100, 0);        push(0, 1, 24'h003200, 24'hFFCE00);
    idle();
    wait_out(base + 3);
    cmp("sat", base);
    chk("sat frame_len", last_len, 3);
`ifdef DFT_NORM_SAT_CNT_EN
    chk("sat_cnt", sat_cnt, 2);
`endif

    // three back-to-back frames under random backpressure
    base = got_q.size(); l0 = len_pulses; e0 = err_cnt;
    @(negedge clk);
    track = 1; rnd_rdy = 1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 12; i++) begin
        v = f * 100 + i + 1;
        send(i == 0, i == 11, v, -v, (i == 0) ? f + 1 : 9);
        push(i == 0, i == 11, shf(v, f + 1), shf(-v, f + 1));
      end
    idle();
    wait_out(base + 36);
    rnd_rdy = 0;
    @(negedge clk) track = 0;
    cmp("bp", base);
    chk("bp full stall ready", full_viol, 0);
    chk("bp len pulses", len_pulses - l0, 3);
    chk("bp frame_len", last_len, 12);
    chk("bp no err", err_cnt - e0, 0);

    // beats before any sop are dropped
    base = got_q.size(); e0 = err_cnt;
    send(0, 0, 7, 7, 0);
    send(0, 1, 8, 8, 0);
    send(0, 0, 9, 9, 0);
    for (int i = 0; i < 4; i++) begin
      send(i == 0, i == 3, i + 1, -(i + 1), 2);
      push(i == 0, i == 3, shf(i + 1, 2), shf(-(i + 1), 2));
    end
    idle();
    wait_out(base + 4);
    chk("drop err count", err_cnt - e0, 3);
    cmp("drop", base);
    chk("drop frame_len", last_len, 4);

    // sop at beat 5 restarts the frame
    base = got_q.size(); e0 = err_cnt; l0 = len_pulses;
    for (int i = 0; i < 12; i++) begin
      v = i + 10;
      send(i == 0 || i == 4, i == 11, v, -v, (i == 0) ? 1 : (i == 4) ? 3 : 6);
      push(i == 0 || i == 4, i == 11, shf(v, (i < 4) ? 1 : 3), shf(-v, (i < 4) ? 1 : 3));
    end
    idle();
    wait_out(base + 12);
    cmp("resop", base);
    chk("resop err", err_cnt - e0, 1);
    chk("resop len pulses", len_pulses - l0, 1);
    chk("resop frame_len", last_len, 8);

    // reset mid-frame with the output stalled
    hold_rdy = 0;
    send(1, 0, 5, 5, 0);
    send(0, 0, 6, 6, 0);
    #1;
    chk("stall sink_ready", snk.ready, 0);
    chk("stall source_real", src.re, 5);
    idle();
    @(negedge clk) rst = 1'b1;
    #1;
    chk("midrst source_valid", src.valid, 0);
    chk("midrst source_real", src.re, 0);
    chk("midrst frame_len", frame_len, 0);
    chk("midrst sink_ready", snk.ready, 0);
    @(negedge clk) rst = 1'b0;
    hold_rdy = 1;
    base = got_q.size(); e0 = err_cnt; l0 = len_pulses;
    send(0, 1, 9, 9, 0);
    send(1, 1, 3, -3, 2);
    push(1, 1, shf(3, 2), shf(-3, 2));
    idle();
    wait_out(base + 1);
    chk("postrst err", err_cnt - e0, 1);
    cmp("postrst", base);
    chk("postrst len pulses", len_pulses - l0, 1);
    chk("postrst frame_len", last_len, 1);
    chk("output hold", hold_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dft_exp_normalizer.md
# dft_exp_normalizer

Downstream companion of the mixed-radix DFT core. Takes the core's block-floating-point output stream (per-frame mantissas plus `source_exp`), rescales every sample to a fixed-point word by left-shifting by the frame exponent with saturation, and forwards it on a valid/ready stream. It also checks sop/eop framing and reports frame length, so later stages (demapper, capture logic) see plain fixed-point, well-formed frames.

## Interface
- `IN_W`, 18, mantissa width of sink_real/sink_imag (signed)
- `OUT_W`, 24, output sample width (signed)
- `EXP_W`, 4, exponent width (unsigned shift amount, 0..2^EXP_W-1)
- `LEN_W`, 12, frame-length counter width
- `clk` in 1: single clock
- `rst` in 1: asynchronous, active-high reset
- `sink_valid` in 1: input beat valid
- `sink_ready` out 1: block can accept a beat
- `sink_sop` / `sink_eop` in 1: first / last beat of a DFT frame
- `sink_real`, `sink_imag` in IN_W: signed mantissas
- `sink_exp` in EXP_W: frame exponent, sampled on sop beat only
- `source_valid` out 1, `source_ready` in 1: output handshake
- `source_sop` / `source_eop` out 1: frame markers, aligned with data
- `source_real`, `source_imag` out OUT_W: scaled, saturated samples
- `frame_len` out LEN_W: beat count of last completed frame
- `frame_len_valid` out 1: one-cycle pulse when frame_len updates
- `frame_err` out 1: one-cycle pulse on framing violation

## Operation
- Beat accepted when `sink_valid && sink_ready`; all state changes only on accepted beats.
- Frame FSM, states IDLE and IN_FRAME (reset: IDLE).
  - IDLE + sop: latch `sink_exp`, len counter = 1, forward beat; go IN_FRAME, or stay IDLE if eop on same beat (frame length 1 reported).
  - IDLE + no sop: beat dropped (not forwarded), `frame_err` pulse.
  - IN_FRAME + no sop: forward with latched exponent, counter +1; eop -> report length, go IDLE.
  - IN_FRAME + sop: `frame_err` pulse; beat treated as start of a new frame (exp relatched, counter = 1); no length report for the aborted frame.
- Counter saturates at 2^LEN_W-1; no wrap.
- Arithmetic per component: sign-extend to IN_W+2^EXP_W-1 bits, shift left by latched exp; if result > 2^(OUT_W-1)-1 output that maximum, if < -2^(OUT_W-1) output that minimum, else truncate to OUT_W (exact). Real and imag saturate independently.
- sop/eop pass through with their beat; dropped beats carry no markers downstream.

## Timing
- Two-stage elastic pipeline: stage 1 shift, stage 2 saturate + output register. Each stage loads when empty or when its content moves on in the same cycle.
- `sink_ready` = stage 1 empty or stage 1 advancing this cycle; forced 0 while `rst` is high.
- Latency: accepted beat appears on source 2 cycles later with `source_ready` held 1; throughput 1 beat/cycle.
- `source_ready` low: output held stable, pipeline fills, `sink_ready` drops after at most 2 further accepts; no beat lost or duplicated.
- `frame_len`/`frame_len_valid` and `frame_err` are registered, asserted the cycle after the offending/eop beat is accepted, independent of output backpressure.
- Reset values: `source_valid`, `source_sop`, `source_eop`, `frame_len_valid`, `frame_err` = 0; `source_real`, `source_imag`, `frame_len` = 0; FSM IDLE; pipeline empty.
- Reset mid-frame: pipeline contents discarded, no eop emitted; the next beat must carry sop or is dropped with `frame_err`.

## Configuration
- `DFT_NORM_SAT_CNT_EN` defined: adds output `sat_cnt` (16 bits) counting saturated components (real and imag each count 1) in the current frame; cleared to 0 on each accepted sop beat and on reset, holds at 0xFFFF; readable until the next sop.
- Not defined: port and counter absent; saturation behaviour unchanged.

## Test plan
- 1200-beat frame, exp=0, ramp real=n, imag=-n, source_ready=1 -> outputs identical values sign-extended, first out 2 cycles after first accept, frame_len=1200 pulse once.
- exp=7, real=18'h1FFFF, imag=18'h20000 -> source_real=24'h7FFFFF, source_imag=24'h800000; real=100 -> 12800; with macro sat_cnt=2 for that beat pair.
- Random source_ready (50%) over three back-to-back 12-beat frames -> output order and sop/eop exact, no loss, sink_ready never high while pipeline full and stalled.
- Beats before any sop -> dropped, frame_err per beat, nothing on source; following sop frame passes cleanly.
- sop at beat 5 of a 12-beat frame -> frame_err pulse, new frame starts, eventual frame_len=8 reported, sink_exp changes mid-frame ignored.
- rst asserted mid-frame with outputs stalled -> all outputs 0 immediately, FSM IDLE; single-beat frame (sop+eop) afterwards -> frame_len=1.
